// File: rtl/sdram_pkg.sv
// sdram_pkg: shared SDRAM command, error, monitor-state and mode-register definitions
//   cmd_e       : {cs_n,ras_n,cas_n,we_n} encodings (DESELECT folded to 4'b1111)
//   err_e       : violation codes 1..7, 0 = none
//   mon_state_e : init monitor states
//   mode_legal  : mode-register opcode legality check
package sdram_pkg;
  typedef enum logic [3:0] {
    CMD_MRS = 4'b0000, CMD_REF = 4'b0001, CMD_PRE = 4'b0010, CMD_ACT = 4'b0011,
    CMD_WR = 4'b0100, CMD_RD = 4'b0101, CMD_BST = 4'b0110, CMD_NOP = 4'b0111,
    CMD_DESEL = 4'b1111
  } cmd_e;
  typedef enum logic [2:0] {
    ERR_NONE, ERR_PWR, ERR_SEQ, ERR_TRP, ERR_TRFC, ERR_REFCNT, ERR_MODE, ERR_TMRD
  } err_e;
  typedef enum logic [2:0] {WAIT_PWR, WAIT_REF, REFS, MRD, DONE, ERROR} mon_state_e;
  localparam int MR_BL_LSB = 0, MR_BT = 3, MR_CAS_LSB = 4, MR_OP_LSB = 7, MR_WB = 9;
  localparam logic [2:0] CAS_2 = 3'd2, CAS_3 = 3'd3, BL_MAX_FIXED = 3'd3, BL_FULL = 3'b111;
  // full-page burst is only defined for sequential burst type
  function automatic logic mode_legal(input logic [12:0] mr);
    logic [2:0] bl, cas;
    bl = mr[MR_BL_LSB+:3];
    cas = mr[MR_CAS_LSB+:3];
    return (cas == CAS_2 || cas == CAS_3) && (bl <= BL_MAX_FIXED || (bl == BL_FULL && !mr[MR_BT]))
      && mr[MR_OP_LSB+:2] == 2'b00;
  endfunction
endpackage

// File: rtl/sdram_cmd_decode.sv
// sdram_cmd_decode: combinational SDRAM pin decode and mode-register check
//   in  cs_n, ras_n, cas_n, we_n : command pins
//   in  addr[12:0]               : address / mode opcode
//   out cmd                      : decoded command
//   out is_nop                   : NOP or DESELECT
//   out is_pall                  : PRECHARGE with addr[10] set
//   out mode_ok                  : addr is a legal mode-register opcode
module sdram_cmd_decode
  import sdram_pkg::*;
(
  input  logic        cs_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        we_n,
  input  logic [12:0] addr,
  output cmd_e        cmd,
  output logic        is_nop,
  output logic        is_pall,
  output logic        mode_ok
);
  assign cmd = cs_n ? CMD_DESEL : cmd_e'({1'b0, ras_n, cas_n, we_n});
  assign is_nop = cmd == CMD_NOP || cmd == CMD_DESEL;
  assign is_pall = cmd == CMD_PRE && addr[10];
  assign mode_ok = mode_legal(addr);
endmodule

// File: rtl/sdram_init_monitor.sv
// sdram_init_monitor: device-side checker of the SDRAM power-up/init command sequence
//   in  iclk, ctr_reset (async, active-high), cke, cs_n/ras_n/cas_n/we_n, ba, addr, dqm
//   out init_done, init_err (sticky), err_code (first violation), mode_* (latched MR fields),
//       ref_count (REFs since PALL, saturating), state_dbg (mon_state_e encoding)
module sdram_init_monitor
  import sdram_pkg::*;
#(
  parameter int T_POWERUP = 10000,
  parameter int T_RP = 1,
  parameter int T_RFC = 2,
  parameter int T_MRD = 2,
  parameter int REF_MIN = 8
) (
  input  logic        iclk,
  input  logic        ctr_reset,
  input  logic        cke,
  input  logic        cs_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        we_n,
  input  logic [1:0]  ba,
  input  logic [12:0] addr,
  input  logic [1:0]  dqm,
  output logic        init_done,
  output logic        init_err,
  output logic [2:0]  err_code,
  output logic [2:0]  mode_burst_len,
  output logic        mode_burst_type,
  output logic [2:0]  mode_cas_lat,
  output logic        mode_wb_single,
  output logic [7:0]  ref_count,
  output logic [2:0]  state_dbg
);
  localparam logic [15:0] PWR_LIM = 16'(T_POWERUP), RP_LIM = 16'(T_RP);
  localparam logic [15:0] RFC_LIM = 16'(T_RFC), MRD_LIM = 16'(T_MRD);
  localparam logic [7:0] REF_LIM = 8'(REF_MIN);
  mon_state_e state;
  cmd_e cmd;
  err_e st_err, err;
  logic [15:0] pwr_cnt, gap_cnt;
  logic is_nop, is_pall, mode_ok, bad_pins, unused_ba;
  sdram_cmd_decode u_dec (
    .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .addr(addr),
    .cmd(cmd), .is_nop(is_nop), .is_pall(is_pall), .mode_ok(mode_ok)
  );
  assign unused_ba = ^ba;
  assign state_dbg = state;
  assign bad_pins = state inside {WAIT_PWR, WAIT_REF, REFS, MRD} && (!cke || dqm != 2'b11);
  // state-specific violation first, then merge in the pin check keeping the lowest code
  always_comb begin
    st_err = ERR_NONE;
    if (!is_nop)
      case (state)
        WAIT_PWR: st_err = pwr_cnt < PWR_LIM ? ERR_PWR : is_pall ? ERR_NONE : ERR_SEQ;
        WAIT_REF: st_err = cmd == CMD_REF ? (gap_cnt < RP_LIM ? ERR_TRP : ERR_NONE)
                         : is_pall ? ERR_NONE : ERR_SEQ;
        REFS:     st_err = cmd == CMD_REF ? (gap_cnt < RFC_LIM ? ERR_TRFC : ERR_NONE)
                         : cmd != CMD_MRS ? ERR_SEQ
                         : gap_cnt < RFC_LIM ? ERR_TRFC
                         : ref_count < REF_LIM ? ERR_REFCNT
                         : mode_ok ? ERR_NONE : ERR_MODE;
        MRD:      st_err = gap_cnt >= MRD_LIM ? ERR_NONE : ERR_TMRD;
        DONE:     st_err = cmd == CMD_MRS && !mode_ok ? ERR_MODE : ERR_NONE;
        default:  st_err = ERR_NONE;
      endcase
    err = bad_pins && (st_err == ERR_NONE || st_err > ERR_SEQ) ? ERR_SEQ : st_err;
  end
  always_ff @(posedge iclk or posedge ctr_reset)
    if (ctr_reset) begin
      state <= WAIT_PWR;
      pwr_cnt <= '0;
      gap_cnt <= '0;
      ref_count <= '0;
      init_done <= 1'b0;
      init_err <= 1'b0;
      err_code <= '0;
      mode_burst_len <= '0;
      mode_burst_type <= 1'b0;
      mode_cas_lat <= '0;
      mode_wb_single <= 1'b0;
    end else begin
      if (cke && pwr_cnt != '1) pwr_cnt <= pwr_cnt + 16'd1;
      gap_cnt <= !is_nop ? 16'd1 : gap_cnt == '1 ? gap_cnt : gap_cnt + 16'd1;
      if (err != ERR_NONE) begin
        state <= ERROR;
        init_err <= 1'b1;
        err_code <= err;
      end else begin
        case (state)
          WAIT_PWR: if (is_pall) state <= WAIT_REF;
          WAIT_REF:
            if (is_pall) ref_count <= '0;
            else if (cmd == CMD_REF) begin
              state <= REFS;
              ref_count <= 8'd1;
            end
          REFS:
            if (cmd == CMD_REF) ref_count <= ref_count == '1 ? ref_count : ref_count + 8'd1;
            else if (cmd == CMD_MRS) state <= MRD;
          MRD:
            if (gap_cnt >= MRD_LIM) begin
              state <= DONE;
              init_done <= 1'b1;
            end
          default: ;
        endcase
        if (cmd == CMD_MRS && state inside {REFS, DONE}) begin
          mode_burst_len <= addr[MR_BL_LSB+:3];
          mode_burst_type <= addr[MR_BT];
          mode_cas_lat <= addr[MR_CAS_LSB+:3];
          mode_wb_single <= addr[MR_WB];
        end
      end
    end
endmodule

// File: doc/sdram_init_monitor.md
Name: sdram_init_monitor

Overview:
- Device-side responder and checker for the SDRAM initialization protocol; it is the SDRAM end of the link driven by the team's initializer.
- Samples the SDRAM command pins every iclk cycle and walks the JEDEC power-up sequence: power-up wait, PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE REGISTER.
- Reports completion, decoded mode-register fields, and the first protocol or timing violation.
- Used in simulation benches and on-board, with flags exported to GPIO for logic-analyser capture.

Parameters:
- T_POWERUP, 10000: minimum NOP/DESELECT cycles after reset release before the first command.
- T_RP, 1: minimum cycles from PRECHARGE ALL to the next command.
- T_RFC, 2: minimum cycles from AUTO REFRESH to the next command.
- T_MRD, 2: cycles after MRS before init_done; no command is allowed inside this window.
- REF_MIN, 8: minimum AUTO REFRESH count before MRS.

Ports:
- iclk  in  1  clock; all sampling on the rising edge.
- ctr_reset  in  1  reset, asynchronous, active-high.
- cke  in  1  SDRAM clock enable.
- cs_n, ras_n, cas_n, we_n  in  1 each  command pins.
- ba  in  2  bank select.
- addr  in  13  address / mode opcode.
- dqm  in  2  {udqm,ldqm}; must be 2'b11 until init_done, otherwise SEQ error.
- init_done  out  1  sequence complete and legal; sticky.
- init_err  out  1  violation seen; sticky.
- err_code  out  3  first violation code.
- mode_burst_len  out  3  MR[2:0].
- mode_burst_type  out  1  MR[3].
- mode_cas_lat  out  3  MR[6:4].
- mode_wb_single  out  1  MR[9].
- ref_count  out  8  AUTO REFRESH count since PRECHARGE ALL; saturates at 255.
- state_dbg  out  3  current state encoding.

Behaviour:
- Reset values: all outputs 0; cycle counter 0; state WAIT_PWR.
  - Reset is asynchronous and may be asserted in any state; everything clears and the power-up count restarts.
- Command decode on {cs_n,ras_n,cas_n,we_n}:
  - 1xxx = DESELECT, treated as NOP.
  - 0111 = NOP.
  - 0010 = PRE; it is PALL when addr[10]=1.
  - 0001 = REF.
  - 0000 = MRS.
  - 0011 = ACT; 0101 = RD; 0100 = WR; 0110 = BST.
- Counters:
  - pwr_cnt (16b, saturating) counts cycles with cke=1 since reset.
  - gap_cnt (16b, saturating) counts cycles since the last non-NOP command. It is 1 on the cycle right after a command.
- WAIT_PWR: NOP only.
  - Any other command while pwr_cnt<T_POWERUP gives err 1 (PWR).
  - PALL with pwr_cnt>=T_POWERUP goes to WAIT_REF.
  - Any other command gives err 2 (SEQ).
- WAIT_REF:
  - REF with gap_cnt>=T_RP goes to REFS, ref_count=1.
  - REF with gap_cnt<T_RP gives err 3 (TRP).
  - PALL again is legal, restarts the gap and clears ref_count.
  - Any other command gives err 2.
- REFS:
  - REF with gap_cnt>=T_RFC increments ref_count; gap_cnt<T_RFC gives err 4 (TRFC).
  - MRS: timing is checked first (gap_cnt<T_RFC gives err 4).
    - ref_count<REF_MIN gives err 5 (REFCNT).
    - Otherwise the mode check runs; on pass, latch the mode_* fields and go to MRD.
  - Any other command gives err 2.
- Mode check, on failure err 6 (MODE):
  - CAS must be 010 or 011.
  - BL must be one of 000, 001, 010, 011, or 111; 111 requires BT=0.
  - addr[8:7] must be 00.
  - addr[12:10] is ignored.
- MRD:
  - Any non-NOP command before T_MRD cycles have elapsed gives err 7 (TMRD).
  - The cycle gap_cnt reaches T_MRD: go to DONE and set init_done.
  - init_done is therefore registered T_MRD edges after the MRS sample edge.
- DONE:
  - All commands accepted.
  - A later MRS re-latches the mode fields only if it passes the mode check; otherwise err 6.
  - No further timing checks.
- ERROR:
  - Entered on any violation; init_err=1.
  - err_code holds the first violation only; init_done stays 0.
  - Held until reset.
- Other error conditions:
  - cke=0 in any state before DONE gives err 2.
  - dqm!=2'b11 before DONE gives err 2.
- Simultaneous violations: report the lowest code.
- Outputs are registered; an error is visible one cycle after the offending sample edge.

Decomposition:
- Shared package sdram_pkg, also imported by the initializer:
  - cmd_e pin encodings.
  - err_e codes 1..7.
  - mon_state_e: WAIT_PWR, WAIT_REF, REFS, MRD, DONE, ERROR.
  - Mode-register field bit positions.
  - Legal CAS/BL constants.
- Sub-module sdram_cmd_decode: combinational pins-to-cmd_e decode plus the mode-legality check. It is reusable by a future read/write monitor.

Test Plan:
- Legal sequence: 10000 NOPs; PALL addr=0x0400; 8 REFs alternating with 1 NOP; MRS addr=0x0023.
  -> init_done=1 two edges after MRS; burst_len=3, cas_lat=2, burst_type=0, wb_single=0; ref_count=8; init_err=0.
- PALL at cycle 500 -> init_err=1, err_code=1; stays latched through a later legal sequence.
- REF on the cycle directly after a REF (gap 1) -> err_code=4; init_done stays 0.
- MRS after only 5 REFs -> err_code=5; mode_* fields stay 0.
- MRS addr=0x0073 (CAS=7) after 8 REFs -> err_code=6.
- ctr_reset asserted mid-REFS (ref_count=4):
  -> all outputs 0 immediately, state_dbg=WAIT_PWR.
  -> then a full legal sequence gives init_done=1 with ref_count=8.
